// File: rtl/instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : instr_issue_ctrl
// Brief   : Issue stage that decodes one instruction per 4 clocks into the
//           ALU control word, one-hot register write enable and carry-in.
// Revision: 1.0 - initial release
// ============================================================================
module instr_issue_ctrl #(
   parameter int NREG      = 16,
   parameter int FLAG_W    = 5,
   parameter int CARRY_BIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   input  logic [FLAG_W-1:0] flags_in,
   output logic [15:0]       alu_code,
   output logic [NREG-1:0]   reg_en,
   output logic              cin,
   output logic [FLAG_W-1:0] flags_q,
   output logic              halted,
   output logic [15:0]       retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_FLAGS  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] c_OP_ALU  = 4'h0;
   localparam logic [3:0] c_OP_HALT = 4'hF;
   localparam logic [3:0] c_EXT_NOP = 4'h0;
   localparam logic [3:0] c_EXT_CMP = 4'hB;
   localparam logic [3:0] c_EXT_ADDC = 4'h7;

   state_t              r_state;
   logic [15:0]         r_alu_code;
   logic [NREG-1:0]     r_reg_en;
   logic                r_cin;
   logic [FLAG_W-1:0]   r_flags_q;
   logic                r_halted;
   logic [15:0]         r_retired;

   logic                w_writes;
   logic [NREG-1:0]     w_onehot;

   assign w_writes = (r_alu_code[15:12] == c_OP_ALU) &&
                     (r_alu_code[7:4] != c_EXT_NOP) &&
                     (r_alu_code[7:4] != c_EXT_CMP);
   assign w_onehot = {{(NREG-1){1'b0}}, 1'b1} << r_alu_code[3:0];

   // Gated with reset so upstream never sees ready while the stage is held in reset.
   assign instr_ready = reset && (r_state == S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_alu_code <= '0;
         r_reg_en   <= '0;
         r_cin      <= 1'b0;
         r_flags_q  <= '0;
         r_halted   <= 1'b0;
         r_retired  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (instr_valid) begin
                  r_alu_code <= instr;
                  if (instr[15:12] == c_OP_HALT) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state <= S_DECODE;
                     r_cin   <= (instr[15:12] == c_OP_ALU && instr[7:4] == c_EXT_ADDC) ?
                                r_flags_q[CARRY_BIT] : 1'b0;
                  end
               end
            end
            S_DECODE: begin
               r_reg_en <= w_writes ? w_onehot : '0;
               r_state  <= S_EXEC;
            end
            S_EXEC: begin
               r_reg_en <= '0;
               r_state  <= S_FLAGS;
            end
            S_FLAGS: begin
               r_flags_q <= flags_in;
               r_retired <= r_retired + 16'd1;
               r_cin     <= 1'b0;
               r_state   <= S_IDLE;
            end
            S_HALT: begin
               r_reg_en <= '0;
               r_halted <= 1'b1;
            end
            default: begin
               r_reg_en <= '0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign alu_code = r_alu_code;
   assign reg_en   = r_reg_en;
   assign cin      = r_cin;
   assign flags_q  = r_flags_q;
   assign halted   = r_halted;
   assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_issue_ctrl
// Brief   : Directed self-checking bench for instr_issue_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [4:0]  flags_in;
   logic [15:0] alu_code;
   logic [15:0] reg_en;
   logic        cin;
   logic [4:0]  flags_q;
   logic        halted;
   logic [15:0] retired;

   int tests;
   int fails;

   instr_issue_ctrl #(.NREG(16), .FLAG_W(5), .CARRY_BIT(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .flags_in    (flags_in),
      .alu_code    (alu_code),
      .reg_en      (reg_en),
      .cin         (cin),
      .flags_q     (flags_q),
      .halted      (halted),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Presents one word for exactly one edge; returns 1 time unit after that edge.
   task automatic accept(input logic [15:0] w);
      @(negedge clk);
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (alu_code !== 16'h0) begin fails++; $display("FAIL reset_alu_code got %h want 0000", alu_code); end
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL reset_reg_en got %h want 0000", reg_en); end
      tests++; if (cin !== 1'b0) begin fails++; $display("FAIL reset_cin got %b want 0", cin); end
      tests++; if (flags_q !== 5'h0) begin fails++; $display("FAIL reset_flags_q got %h want 00", flags_q); end
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
      tests++; if (retired !== 16'h0) begin fails++; $display("FAIL reset_retired got %h want 0000", retired); end
      tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low got %b want 0", instr_ready); end
      reset = 1'b1;
      #1;
      tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_high got %b want 1", instr_ready); end
   endtask

   task automatic test_single_write;
      flags_in = 5'h00;
      accept(16'h0051);
      tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL w1_ready_decode got %b want 0", instr_ready); end
      tests++; if (alu_code !== 16'h0051) begin fails++; $display("FAIL w1_alu_code got %h want 0051", alu_code); end
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL w1_reg_en_decode got %h want 0000", reg_en); end
      step;
      tests++; if (reg_en !== 16'h0002) begin fails++; $display("FAIL w1_reg_en_exec got %h want 0002", reg_en); end
      step;
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL w1_reg_en_flags got %h want 0000", reg_en); end
      tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL w1_ready_flags got %b want 0", instr_ready); end
      step;
      tests++; if (retired !== 16'd1) begin fails++; $display("FAIL w1_retired got %0d want 1", retired); end
      tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL w1_ready_back got %b want 1", instr_ready); end
   endtask

   task automatic test_addc;
      flags_in = 5'h08;
      accept(16'h0003);
      repeat (3) step;
      tests++; if (flags_q !== 5'h08) begin fails++; $display("FAIL addc_carry_stored got %h want 08", flags_q); end
      accept(16'h0172);
      tests++; if (cin !== 1'b1) begin fails++; $display("FAIL addc_cin_decode got %b want 1", cin); end
      step;
      tests++; if (cin !== 1'b1) begin fails++; $display("FAIL addc_cin_exec got %b want 1", cin); end
      tests++; if (reg_en !== 16'h0004) begin fails++; $display("FAIL addc_reg_en got %h want 0004", reg_en); end
      step;
      tests++; if (cin !== 1'b1) begin fails++; $display("FAIL addc_cin_flags got %b want 1", cin); end
      flags_in = 5'h00;
      step;
      tests++; if (cin !== 1'b0) begin fails++; $display("FAIL addc_cin_idle got %b want 0", cin); end
      tests++; if (flags_q !== 5'h00) begin fails++; $display("FAIL addc_flags_q got %h want 00", flags_q); end
      flags_in = 5'h08;
      accept(16'h0152);
      tests++; if (cin !== 1'b0) begin fails++; $display("FAIL add_cin got %b want 0", cin); end
      step;
      tests++; if (reg_en !== 16'h0004) begin fails++; $display("FAIL add_reg_en got %h want 0004", reg_en); end
      repeat (2) step;
      tests++; if (retired !== 16'd4) begin fails++; $display("FAIL add_retired got %0d want 4", retired); end
   endtask

   task automatic test_nop_cmp;
      flags_in = 5'h15;
      accept(16'h0003);
      step;
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL nop_reg_en got %h want 0000", reg_en); end
      repeat (2) step;
      tests++; if (flags_q !== 5'h15) begin fails++; $display("FAIL nop_flags_q got %h want 15", flags_q); end
      flags_in = 5'h0A;
      accept(16'h01B2);
      step;
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL cmp_reg_en got %h want 0000", reg_en); end
      repeat (2) step;
      tests++; if (flags_q !== 5'h0A) begin fails++; $display("FAIL cmp_flags_q got %h want 0a", flags_q); end
      tests++; if (retired !== 16'd6) begin fails++; $display("FAIL nop_cmp_retired got %0d want 6", retired); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] q[3];
      logic [15:0] exp_en[3];
      logic [15:0] seen[$];
      int          acc[3];
      int          idx;
      logic        rdy;
      q      = '{16'h0051, 16'h0162, 16'h0183};
      exp_en = '{16'h0002, 16'h0004, 16'h0008};
      idx    = 0;
      flags_in = 5'h00;
      for (int c = 0; c < 40 && idx < 3; c++) begin
         @(negedge clk);
         instr       = q[idx];
         instr_valid = 1'b1;
         rdy         = instr_ready;
         @(posedge clk);
         if (rdy) begin
            acc[idx] = c;
            idx++;
         end
         #1;
         if (idx == 3) instr_valid = 1'b0;
         if (reg_en !== 16'h0) seen.push_back(reg_en);
      end
      instr_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step;
         if (reg_en !== 16'h0) seen.push_back(reg_en);
      end
      tests++; if (idx !== 3) begin fails++; $display("FAIL b2b_accepted got %0d want 3", idx); end
      if (idx == 3) begin
         tests++; if (acc[1] - acc[0] !== 4) begin fails++; $display("FAIL b2b_gap01 got %0d want 4", acc[1] - acc[0]); end
         tests++; if (acc[2] - acc[1] !== 4) begin fails++; $display("FAIL b2b_gap12 got %0d want 4", acc[2] - acc[1]); end
      end
      tests++; if (seen.size() !== 3) begin fails++; $display("FAIL b2b_writes got %0d want 3", seen.size()); end
      for (int i = 0; i < 3 && i < seen.size(); i++) begin
         tests++; if (seen[i] !== exp_en[i]) begin fails++; $display("FAIL b2b_reg_en%0d got %h want %h", i, seen[i], exp_en[i]); end
      end
      tests++; if (retired !== 16'd9) begin fails++; $display("FAIL b2b_retired got %0d want 9", retired); end
   endtask

   task automatic test_halt;
      accept(16'hF000);
      tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_halted got %b want 1", halted); end
      tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL halt_ready got %b want 0", instr_ready); end
      @(negedge clk);
      instr       = 16'h0051;
      instr_valid = 1'b1;
      repeat (5) step;
      instr_valid = 1'b0;
      tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL halt_ready_hold got %b want 0", instr_ready); end
      tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_hold got %b want 1", halted); end
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL halt_reg_en got %h want 0000", reg_en); end
      tests++; if (retired !== 16'd9) begin fails++; $display("FAIL halt_retired got %0d want 9", retired); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_cleared got %b want 0", halted); end
      @(negedge clk);
      reset = 1'b1;
      accept(16'h0051);
      step;
      tests++; if (reg_en !== 16'h0002) begin fails++; $display("FAIL abort_exec_en got %h want 0002", reg_en); end
      #1;
      reset = 1'b0;
      #1;
      tests++; if (reg_en !== 16'h0) begin fails++; $display("FAIL abort_reg_en got %h want 0000", reg_en); end
      tests++; if (retired !== 16'd0) begin fails++; $display("FAIL abort_retired got %0d want 0", retired); end
      @(negedge clk);
      reset = 1'b1;
      repeat (4) step;
      tests++; if (retired !== 16'd0) begin fails++; $display("FAIL abort_retired_after got %0d want 0", retired); end
      tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", instr_ready); end
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      reset       = 1'b0;
      instr_valid = 1'b0;
      instr       = 16'h0;
      flags_in    = 5'h0;
      test_reset;
      test_single_write;
      test_addc;
      test_nop_cmp;
      test_back_to_back;
      test_halt;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
